// File: rtl/seq_mag_comparator.sv
// seq_mag_comparator
//   Multi-cycle magnitude comparator. Compares two WIDTH-bit operands
//   MSB-first, DIGIT bits per clock, and stops at the first differing digit.
//   When every digit matches, the result comes from the cascade inputs
//   (eq_in/gt_in), so the block can sit behind a less-significant stage.
//   A signed_mode flag selects a two's-complement compare.
//
// Ports
//   clk, rst_n         clock, async active-low reset
//   start              request; accepted when busy=0 (IDLE or HOLD)
//   A, B               operands, latched on acceptance
//   eq_in, gt_in       cascade "lower part equal / greater", latched
//   signed_mode        1 = two's-complement compare, latched
//   busy               scan in progress
//   done               one-cycle pulse, result valid
//   EQ, GT, LT         result flags; held until the next acceptance
//   digits             number of digits examined for the last result
module seq_mag_comparator #(
  parameter  int WIDTH = 16,
  parameter  int DIGIT = 4,
  localparam int N     = WIDTH / DIGIT,
  localparam int CW    = $clog2(N + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             eq_in,
  input  logic             gt_in,
  input  logic             signed_mode,
  output logic             busy,
  output logic             done,
  output logic             EQ,
  output logic             GT,
  output logic             LT,
  output logic [CW-1:0]    digits
);

  typedef enum logic [1:0] {IDLE, SCAN, HOLD} state_t;

  localparam logic [WIDTH-1:0] MSB  = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CW-1:0]    LAST = CW'(N - 1);

  state_t           state, nxt;
  logic [WIDTH-1:0] a_sh, b_sh;   // operands, shifted left one digit per step
  logic             c_eq, c_gt;   // latched cascade inputs
  logic [CW-1:0]    idx;          // index of the digit under compare
  logic [DIGIT-1:0] da, db;
  logic             dig_ne, dig_gt, last, accept;

  // The current digit always sits at the top of the shift registers.
  assign da     = a_sh[WIDTH-1 -: DIGIT];
  assign db     = b_sh[WIDTH-1 -: DIGIT];
  assign dig_ne = (da != db);
  assign dig_gt = (da > db);
  assign last   = (idx == LAST);
  assign accept = start && (state != SCAN);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state logic
  always_comb begin
    nxt = state;
    case (state)
      IDLE, HOLD: if (start)          nxt = SCAN;
      SCAN:       if (dig_ne || last) nxt = HOLD;
      default:                        nxt = IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    busy = (state == SCAN);
  end

  // Datapath and registered result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      c_eq   <= 1'b0;
      c_gt   <= 1'b0;
      idx    <= '0;
      done   <= 1'b0;
      EQ     <= 1'b0;
      GT     <= 1'b0;
      LT     <= 1'b0;
      digits <= '0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        // Flipping both sign bits maps two's-complement order onto
        // unsigned order, so the scan itself never needs to know the mode.
        a_sh   <= signed_mode ? (A ^ MSB) : A;
        b_sh   <= signed_mode ? (B ^ MSB) : B;
        c_eq   <= eq_in;
        c_gt   <= gt_in;
        idx    <= '0;
        EQ     <= 1'b0;
        GT     <= 1'b0;
        LT     <= 1'b0;
        digits <= '0;
      end else if (state == SCAN) begin
        if (dig_ne) begin
          EQ     <= 1'b0;
          GT     <= dig_gt;
          LT     <= !dig_gt;
          digits <= idx + CW'(1);
          done   <= 1'b1;
        end else if (last) begin
          // All digits equal: the lower stage decides; gt_in is moot when eq_in.
          EQ     <= c_eq;
          GT     <= !c_eq && c_gt;
          LT     <= !c_eq && !c_gt;
          digits <= CW'(N);
          done   <= 1'b1;
        end else begin
          idx  <= idx + CW'(1);
          a_sh <= a_sh << DIGIT;
          b_sh <= b_sh << DIGIT;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_mag_comparator.sv
module tb_seq_mag_comparator;
  localparam int W  = 16;
  localparam int D  = 4;
  localparam int N  = W / D;
  localparam int CW = $clog2(N + 1);

  logic          clk, rst_n, start, eq_in, gt_in, signed_mode;
  logic [W-1:0]  A, B;
  logic          busy, done, EQ, GT, LT;
  logic [CW-1:0] digits;

  int checks = 0;
  int errors = 0;

  seq_mag_comparator #(.WIDTH(W), .DIGIT(D)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .eq_in(eq_in), .gt_in(gt_in), .signed_mode(signed_mode),
    .busy(busy), .done(done), .EQ(EQ), .GT(GT), .LT(LT), .digits(digits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer compare, first differing digit found by slicing
  // the raw operands (sign flipping never changes which digits differ).
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic eqi, input logic gti, input logic sm,
                                output logic [2:0] egl, output int d);
    logic [W-1:0] mask;
    bit found;
    mask  = (W'(1) << D) - W'(1);
    found = 0;
    d     = N;
    for (int k = 0; k < N; k++)
      if (!found && (((a >> (W - (k + 1) * D)) & mask) != ((b >> (W - (k + 1) * D)) & mask))) begin
        found = 1;
        d     = k + 1;
      end
    if (a == b)      egl = eqi ? 3'b100 : (gti ? 3'b010 : 3'b001);
    else if (sm)     egl = ($signed(a) > $signed(b)) ? 3'b010 : 3'b001;
    else             egl = (a > b) ? 3'b010 : 3'b001;
  endfunction

  // Called #1 after an edge; drives a request, checks the whole operation and
  // returns #1 after the done edge. poke>=0 injects a start that many cycles in.
  task automatic do_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic eqi, input logic gti, input logic sm, input int poke);
    logic [2:0] e;
    int d, cyc;
    model(a, b, eqi, gti, sm, e, d);
    A = a; B = b; eq_in = eqi; gt_in = gti; signed_mode = sm; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    A = W'($urandom); B = W'($urandom);
    eq_in = 1'($urandom); gt_in = 1'($urandom); signed_mode = 1'($urandom);
    chk("busy_acc", busy, 1);
    chk("done_acc", done, 0);
    chk("flags_acc", {EQ, GT, LT}, 0);
    chk("digits_acc", digits, 0);
    cyc = 0;
    while (!done && cyc < N + 2) begin
      if (cyc == poke) begin
        start = 1'b1; A = W'($urandom); B = W'($urandom);
      end
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (!done) chk("busy_scan", busy, 1);
    end
    chk("latency", cyc, d);
    chk("result", {EQ, GT, LT}, e);
    chk("digits", digits, d);
    chk("busy_done", busy, 0);
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0;
    eq_in = 1'b0; gt_in = 1'b0; signed_mode = 1'b0;
    #2;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", {EQ, GT, LT}, 0);
    chk("rst_digits", digits, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Directed cases
    do_cmp(16'h2E2E, 16'h2E2E, 1, 0, 0, -1);
    @(posedge clk); #1;
    chk("hold_done", done, 0);
    chk("hold_flags", {EQ, GT, LT}, 3'b100);
    chk("hold_digits", digits, 4);
    do_cmp(16'h2E2E, 16'h2E2F, 1, 0, 0, -1);
    do_cmp(16'h2F2E, 16'h2E2E, 1, 0, 0, -1);
    do_cmp(16'hAE00, 16'h2E00, 1, 0, 0, -1);
    do_cmp(16'hAE00, 16'h2E00, 1, 0, 1, -1);
    do_cmp(16'h8000, 16'h7FFF, 0, 0, 1, -1);
    do_cmp(16'h1234, 16'h1234, 0, 1, 0, -1);
    do_cmp(16'h1234, 16'h1234, 0, 0, 0, -1);
    do_cmp(16'h1234, 16'h1234, 1, 1, 0, -1);
    do_cmp(16'hFFFF, 16'hFFFF, 0, 1, 1, -1);

    // start while busy is ignored
    do_cmp(16'h5A5A, 16'h5A5A, 1, 0, 0, 2);
    do_cmp(16'h5A50, 16'h5A5F, 0, 0, 0, 1);

    // Back-to-back random sequence: each call starts in the previous done cycle
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      case ($urandom_range(0, 2))
        0:       rb = ra;
        1:       rb = ra ^ (W'(1) << $urandom_range(0, W - 1));
        default: rb = W'($urandom);
      endcase
      do_cmp(ra, rb, 1'($urandom), 1'($urandom), 1'($urandom), -1);
    end

    // Reset during HOLD clears the held result at once
    rst_n = 1'b0; #1;
    chk("rsthold_flags", {EQ, GT, LT}, 0);
    chk("rsthold_digits", digits, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Reset mid-SCAN: everything drops immediately and no done follows
    A = 16'h1234; B = 16'h1234; eq_in = 1'b1; gt_in = 1'b0; signed_mode = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0; #1;
    chk("rstscan_busy", busy, 0);
    chk("rstscan_done", done, 0);
    chk("rstscan_flags", {EQ, GT, LT}, 0);
    chk("rstscan_digits", digits, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("no_done_after_rst", done, 0);
      chk("idle_busy", busy, 0);
    end

    // Normal operation resumes from IDLE
    do_cmp(16'h0001, 16'h0002, 1, 0, 0, -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
